ahb_sram_slave: RTL
===================

# ahb_sram_slave

Word-organised AHB-lite SRAM slave at the bus address window used by the behavioural master (base 0xC200_0000). It decodes address-phase controls from the master, applies optional wait states, performs byte/halfword/word writes, returns read data, and raises a two-cycle ERROR response for illegal transfers. It sits directly downstream of the master, with HSEL from the bus decoder.

## Interface
- ADDR_BASE, 32'hC200_0000: byte address of word 0.
- MEM_DEPTH, 64: number of 32-bit words; power of two, 2..1024.
- WAIT_CYCLES, 1: wait states per legal transfer; range 0..15. Used only with AHB_SLV_WAIT_EN.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  address-phase byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
- HWDATA  in  32  write data, data phase.
- HREADYin  in  1  bus-level HREADY; address phase is sampled only when high.
- HREADYOUT  out  1  slave ready; low extends the data phase.
- HRESP  out  2  OKAY=00, ERROR=01; RETRY/SPLIT are never driven.
- HRDATA  out  32  read data.

## Operation
- Transfer accepted at a rising edge when HSEL=1, HREADYin=1, and HTRANS[1]=1. Accepting latches HADDR, HWRITE, and HSIZE into addr_q, write_q, and size_q.
- IDLE/BUSY, or HSEL=0: no transfer; next data phase is zero-wait OKAY.
- Legality check at acceptance. A transfer is illegal if any of the following holds; illegal transfers never touch memory:
  - HSIZE=11.
  - Misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]≠0.
  - HADDR < ADDR_BASE.
  - (HADDR−ADDR_BASE)>>2 ≥ MEM_DEPTH. Use 32-bit unsigned subtraction; no wrap into range.
- Word index is (HADDR−ADDR_BASE)[log2(MEM_DEPTH)+1:2]. Byte lanes are little-endian: lane n = bits 8n+7:8n.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY.
  - On a legal accept: go to WAIT if the wait count > 0, else DATA.
  - On an illegal accept: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY; a 4-bit counter decrements each cycle; go to DATA when it reaches 1.
  - DATA: HREADYOUT=1, HRESP=OKAY. Completing edge:
    - Write: commits HWDATA lanes selected by size_q/addr_q[1:0] into memory.
    - Simultaneous new accept: follows the IDLE rules (back-to-back pipelining); otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. A new accept is processed as from IDLE. A master that drives IDLE here causes no transfer.
- HRDATA:
  - Read in DATA: HRDATA = mem[word index of addr_q], full word regardless of size.
  - All other cycles: HRDATA = 32'h0.
- Read-after-write to the same word needs no forwarding: the write commits on the edge that starts the read's data phase.
- Memory contents are not reset. Reads of never-written words are undefined in simulation (X permitted).

## Timing
- Reset (async assert, sync-to-HCLK release handled upstream):
  - Outputs: HREADYOUT=1, HRESP=00, HRDATA=0.
  - FSM=IDLE, counter=0.
  - Any in-flight write is dropped.
- Zero-wait legal transfer: data phase is the cycle after the address phase. HRDATA is valid in that cycle; HWDATA is sampled at its end.
- With wait states: data phase lasts WAIT_CYCLES+1 cycles; HREADYOUT is low for the first WAIT_CYCLES.
- ERROR: always exactly 2 data-phase cycles (HREADYOUT 0 then 1, HRESP=01 both), independent of wait configuration.
- Address-phase signals are not re-sampled while HREADYOUT=0. The master holds them, and HREADYin is low then.

## Configuration
- AHB_SLV_WAIT_EN defined: wait-state counter and WAIT state compiled in; WAIT_CYCLES applies to every legal transfer.
- Undefined: no counter, no WAIT state; every legal transfer is zero-wait; WAIT_CYCLES is ignored. Error behaviour is unchanged.

## Test plan
- Reset with outputs checked, no macro: HRESETn low mid-write → HREADYOUT=1, HRESP=00, HRDATA=0 immediately; a later read of that word does not return the aborted data.
- Zero-wait RAW, no macro:
  - NONSEQ word write 0xC200_0000 with data 0xDEAD_BEEF, then back-to-back read of 0xC200_0000 → HRDATA=0xDEAD_BEEF.
  - Both data phases show HREADYOUT=1, HRESP=00.
- Byte lanes: word write 0xC200_0010=0x1122_3344; byte write 0xC200_0012 with HWDATA=0x00AA_0000; halfword write 0xC200_0010 with HWDATA=0x0000_BBCC → read 0xC200_0010 returns 0x11AA_BBCC.
- Errors:
  - Word read at 0xC200_0002, then word write at 0xC200_0100 (MEM_DEPTH=64) → each gets two cycles of HRESP=01, HREADYOUT 0 then 1.
  - No memory word changes; the following legal transfer completes OKAY.
- Wait states, AHB_SLV_WAIT_EN with WAIT_CYCLES=3:
  - Read 0xC200_0004 → HREADYOUT low for exactly 3 cycles, then high with valid HRDATA.
  - Back-to-back reads each take 4 cycles.
- IDLE/BUSY and deselect: HTRANS=IDLE or BUSY with HSEL=1, and NONSEQ with HSEL=0 → zero-wait OKAY, HRDATA=0, memory untouched.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: word-organised AHB-lite SRAM slave with two-cycle ERROR response.
// Optional macro AHB_SLV_WAIT_EN compiles in the WAIT_CYCLES wait-state counter.
module ahb_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'hC200_0000,
    parameter int          MEM_DEPTH   = 64,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    if (MEM_DEPTH < 2 || MEM_DEPTH > 1024 ||
        (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("MEM_DEPTH must be a power of two in 2..1024");
    end

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
`ifdef AHB_SLV_WAIT_EN
        ST_WAIT = 3'd1,
`endif
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
`ifdef AHB_SLV_WAIT_EN
    logic [3:0]  cnt_q, cnt_d;
`endif

    logic [31:0] mem_q [MEM_DEPTH];

    logic             xfer_req;
    logic             accept;
    logic [31:0]      in_off;
    logic             in_legal;
    logic [IDX_W-1:0] dp_idx;
    logic [3:0]       be;
    logic             mem_we;

    // Classify the incoming HTRANS: only NONSEQ and SEQ request a transfer
    always_comb begin
        unique case (HTRANS)
            2'b10, 2'b11: xfer_req = 1'b1;
            default:      xfer_req = 1'b0;
        endcase
    end

    assign accept = HSEL & HREADYin & xfer_req;

    // Legality of the address-phase request; out-of-window never wraps in
    always_comb begin
        in_off   = HADDR - ADDR_BASE;
        in_legal = 1'b1;
        if (HSIZE == 2'b11) begin
            in_legal = 1'b0;
        end
        if (HSIZE == 2'b01 && HADDR[0]) begin
            in_legal = 1'b0;
        end
        if (HSIZE == 2'b10 && HADDR[1:0] != 2'b00) begin
            in_legal = 1'b0;
        end
        if (HADDR < ADDR_BASE) begin
            in_legal = 1'b0;
        end
        if ((in_off >> 2) >= 32'(MEM_DEPTH)) begin
            in_legal = 1'b0;
        end
    end

    assign dp_idx = IDX_W'((addr_q - ADDR_BASE) >> 2);

    // Little-endian byte lanes touched by the latched size/address
    always_comb begin
        be = 4'b0000;
        unique case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Next-state, latch and bus-response logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif
        mem_we    = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        HRDATA    = 32'h0;

        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_q == ST_DATA) begin
                    mem_we = write_q;
                    if (!write_q) begin
                        HRDATA = mem_q[dp_idx];
                    end
                end
                if (state_q == ST_ERR2) begin
                    HRESP = RESP_ERROR;
                end
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = HADDR;
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (!in_legal) begin
                        state_d = ST_ERR1;
`ifdef AHB_SLV_WAIT_EN
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset drops any in-flight transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Storage array: contents survive reset; lanes commit on the completing edge
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule
